// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared widths, command layout, decoder states and register map
package pwm_pkg;

    localparam int ADDR_W     = 6;
    localparam int DATA_W     = 8;
    localparam int CMD_RW_BIT = 7;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_ISSUE = 3'd1,
        RD_CAPT  = 3'd2,
        RD_DUMMY = 3'd3,
        WR_DATA  = 3'd4,
        DONE     = 3'd5
    } dcd_state_e;

    // Register byte addresses shared with the PWM register file
    localparam logic [ADDR_W-1:0] REG_PERIOD_LSB   = 6'h00;
    localparam logic [ADDR_W-1:0] REG_PERIOD_MSB   = 6'h01;
    localparam logic [ADDR_W-1:0] REG_COUNTER_EN   = 6'h02;
    localparam logic [ADDR_W-1:0] REG_COMPARE1_LSB = 6'h03;
    localparam logic [ADDR_W-1:0] REG_COMPARE1_MSB = 6'h04;
    localparam logic [ADDR_W-1:0] REG_COMPARE2_LSB = 6'h05;
    localparam logic [ADDR_W-1:0] REG_COMPARE2_MSB = 6'h06;

    function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
        return a + ADDR_W'(1);
    endfunction

endpackage

// File: rtl/instr_dcd_if.sv
// rtl/instr_dcd_if.sv - bridge-side frame signals and register-file access signals
interface instr_dcd_if;
    import pwm_pkg::*;

    logic              frame_active;
    logic              byte_sync;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_out;
    logic              read;
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data_write;
    logic [DATA_W-1:0] data_read;

    modport master (
        output frame_active, byte_sync, data_in, data_read,
        input  data_out, read, write, addr, data_write
    );

    modport slave (
        input  frame_active, byte_sync, data_in, data_read,
        output data_out, read, write, addr, data_write
    );

endinterface

// File: rtl/instr_dcd.sv
// rtl/instr_dcd.sv - SPI byte-frame to register access decoder
// Optional INSTR_DCD_BURST_EN: auto-incrementing multi-register reads/writes per frame.
module instr_dcd
    import pwm_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    instr_dcd_if.slave  bus
);

    dcd_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_write_q, data_write_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              read_q, read_d;
    logic              write_q, write_d;
`ifdef INSTR_DCD_BURST_EN
    logic              first_q, first_d;
`endif

    logic unused_cmd_bit;
    assign unused_cmd_bit = bus.data_in[6];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            data_write_q <= '0;
            data_out_q   <= '0;
            read_q       <= 1'b0;
            write_q      <= 1'b0;
`ifdef INSTR_DCD_BURST_EN
            first_q      <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            data_write_q <= data_write_d;
            data_out_q   <= data_out_d;
            read_q       <= read_d;
            write_q      <= write_d;
`ifdef INSTR_DCD_BURST_EN
            first_q      <= first_d;
`endif
        end
    end

    // Strobes are registered from the transition that enters the access,
    // so each lands exactly one cycle after the triggering byte_sync.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        data_write_d = data_write_q;
        data_out_d   = data_out_q;
        read_d       = 1'b0;
        write_d      = 1'b0;
`ifdef INSTR_DCD_BURST_EN
        first_d      = first_q;
`endif

        if (!bus.frame_active) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.byte_sync) begin
                        addr_d = bus.data_in[ADDR_W-1:0];
                        if (bus.data_in[CMD_RW_BIT]) begin
                            state_d = WR_DATA;
`ifdef INSTR_DCD_BURST_EN
                            first_d = 1'b1;
`endif
                        end else begin
                            state_d = RD_ISSUE;
                            read_d  = 1'b1;
                        end
                    end
                end
                RD_ISSUE: state_d = RD_CAPT;
                RD_CAPT: begin
                    data_out_d = bus.data_read;
                    state_d    = RD_DUMMY;
                end
                RD_DUMMY: begin
                    if (bus.byte_sync) begin
`ifdef INSTR_DCD_BURST_EN
                        addr_d  = addr_inc(addr_q);
                        state_d = RD_ISSUE;
                        read_d  = 1'b1;
`else
                        state_d = DONE;
`endif
                    end
                end
                WR_DATA: begin
                    if (bus.byte_sync) begin
                        data_write_d = bus.data_in;
                        write_d      = 1'b1;
`ifdef INSTR_DCD_BURST_EN
                        if (!first_q) addr_d = addr_inc(addr_q);
                        first_d = 1'b0;
`else
                        state_d = DONE;
`endif
                    end
                end
                DONE:    state_d = DONE;
                default: state_d = IDLE;
            endcase
        end
    end

    assign bus.data_out   = data_out_q;
    assign bus.read       = read_q;
    assign bus.write      = write_q;
    assign bus.addr       = addr_q;
    assign bus.data_write = data_write_q;

endmodule

// File: tb/tb_instr_dcd.sv
// tb/tb_instr_dcd.sv - randomized frame stimulus checked against a frame-level register model
module tb_instr_dcd;
    import pwm_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    instr_dcd_if bus();

    instr_dcd dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    logic [7:0]  regs [64];
    logic [7:0]  model_mem [64];
    logic [13:0] wq [$];
    logic [5:0]  rq [$];
    logic [7:0]  frame_q [$];
    bit          burst;
    int          errors = 0;
    int          checks = 0;

    // Register file stand-in: registered read data, valid one cycle after read
    always @(posedge clk) begin
        if (!rst_n) begin
            bus.data_read <= '0;
        end else begin
            if (bus.read) bus.data_read <= regs[bus.addr];
            if (bus.write) regs[bus.addr] = bus.data_write;
        end
    end

    always @(negedge clk) begin
        if (bus.write) wq.push_back({bus.addr, bus.data_write});
        if (bus.read)  rq.push_back(bus.addr);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic pulse_byte(input logic [7:0] b);
        @(posedge clk); #1;
        bus.data_in   = b;
        bus.byte_sync = 1'b1;
        @(posedge clk); #1;
        bus.byte_sync = 1'b0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input string tag);
        logic [7:0]  cmd;
        logic [5:0]  a;
        logic [5:0]  wa;
        logic [13:0] exp_w [$];
        logic [5:0]  exp_r [$];
        int n;
        n   = frame_q.size();
        cmd = frame_q[0];
        a   = cmd[5:0];
        wq.delete();
        rq.delete();
        @(posedge clk); #1;
        bus.frame_active = 1'b1;
        for (int i = 0; i < n; i++) begin
            if (!cmd[7] && i > 0)
                check({tag, "/dout_pre"}, 32'(bus.data_out), 32'(model_mem[burst ? 6'(a + i - 1) : a]));
            pulse_byte(frame_q[i]);
        end
        repeat (2) @(posedge clk);
        #1 bus.frame_active = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        if (cmd[7]) begin
            for (int i = 1; i < n; i++) begin
                if (burst || i == 1) begin
                    wa = burst ? 6'(a + i - 1) : a;
                    exp_w.push_back({wa, frame_q[i]});
                    model_mem[wa] = frame_q[i];
                end
            end
        end else begin
            for (int i = 0; i < (burst ? n : 1); i++) exp_r.push_back(6'(a + i));
        end
        check({tag, "/nwr"}, 32'(wq.size()), 32'(exp_w.size()));
        check({tag, "/nrd"}, 32'(rq.size()), 32'(exp_r.size()));
        for (int i = 0; i < exp_w.size() && i < wq.size(); i++)
            check({tag, "/wr"}, 32'(wq[i]), 32'(exp_w[i]));
        for (int i = 0; i < exp_r.size() && i < rq.size(); i++)
            check({tag, "/rdaddr"}, 32'(rq[i]), 32'(exp_r[i]));
        if (!cmd[7])
            check({tag, "/dout"}, 32'(bus.data_out), 32'(model_mem[exp_r[exp_r.size()-1]]));
    endtask

    initial begin
`ifdef INSTR_DCD_BURST_EN
        burst = 1'b1;
`else
        burst = 1'b0;
`endif
        bus.frame_active = 1'b0;
        bus.byte_sync    = 1'b0;
        bus.data_in      = '0;
        for (int i = 0; i < 64; i++) begin
            regs[i]      = 8'($urandom);
            model_mem[i] = regs[i];
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst/read",  32'(bus.read), 0);
        check("rst/write", 32'(bus.write), 0);
        check("rst/addr",  32'(bus.addr), 0);
        check("rst/dw",    32'(bus.data_write), 0);
        check("rst/dout",  32'(bus.data_out), 0);

        frame_q = '{8'h80, 8'h34};
        run_frame("wr1");
        check("wr1/period_lsb", 32'(regs[REG_PERIOD_LSB]), 32'h34);

        regs[REG_COMPARE1_LSB]      = 8'hA5;
        model_mem[REG_COMPARE1_LSB] = 8'hA5;
        frame_q = '{8'h03, 8'h00};
        run_frame("rd2");
        check("rd2/a5", 32'(bus.data_out), 32'hA5);

        frame_q = '{8'h8C};
        run_frame("abort");
        frame_q = '{8'h8C, 8'h6E};
        run_frame("after_abort");

        // Reset one cycle after a write command byte
        wq.delete();
        @(posedge clk); #1;
        bus.frame_active = 1'b1;
        bus.data_in      = 8'h85;
        bus.byte_sync    = 1'b1;
        @(posedge clk); #1;
        bus.byte_sync = 1'b0;
        rst_n         = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("mrst/read",  32'(bus.read), 0);
        check("mrst/write", 32'(bus.write), 0);
        check("mrst/addr",  32'(bus.addr), 0);
        check("mrst/dw",    32'(bus.data_write), 0);
        check("mrst/dout",  32'(bus.data_out), 0);
        pulse_byte(8'h5A);
        check("mrst/nwr", 32'(wq.size()), 0);
        bus.frame_active = 1'b0;
        repeat (3) @(posedge clk);

        // byte_sync coinciding with frame end, then byte_sync while inactive
        @(posedge clk); #1;
        bus.frame_active = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        wq.delete();
        rq.delete();
        bus.data_in      = 8'h81;
        bus.byte_sync    = 1'b1;
        bus.frame_active = 1'b0;
        @(posedge clk); #1;
        bus.byte_sync = 1'b0;
        pulse_byte(8'h05);
        check("simul/nwr", 32'(wq.size()), 0);
        check("simul/nrd", 32'(rq.size()), 0);
        frame_q = '{8'h81, 8'h77};
        run_frame("after_simul");

        frame_q = '{8'hBF, 8'h11, 8'h22};
        run_frame("burst5");
        check("burst5/r3f", 32'(regs[6'h3F]), 32'h11);
        check("burst5/r00", 32'(regs[6'h00]), burst ? 32'h22 : 32'h34);

        for (int f = 0; f < 40; f++) begin
            int n;
            n = $urandom_range(1, 4);
            frame_q.delete();
            for (int i = 0; i < n; i++) frame_q.push_back(8'($urandom));
            run_frame($sformatf("rnd%0d", f));
        end

        begin
            int bad;
            bad = 0;
            for (int i = 0; i < 64; i++) if (regs[i] !== model_mem[i]) bad++;
            check("final/regmap", 32'(bad), 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
